// File: rtl/ps2_kbd_ctrl_if.sv
// ps2_kbd_ctrl_if: bundles the PS/2 receiver outputs, the event FIFO read
// port, status/flow-control signals of the keyboard controller.
//   rx_data/rx_valid/rx_error : byte stream from the PS/2 receiver
//   evt_*                     : FIFO head event (first-word fall-through)
//   evt_ready                 : consumer pop
//   fifo_count, overflow,
//   err_count, clr_status     : status and its clear strobe
//   ps2_clk_inhibit           : host flow control towards the PS/2 clock
// slave = the controller, master = the side driving the receiver/consumer.
interface ps2_kbd_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic                          rx_error;
  logic                          ps2_clk_inhibit;
  logic                          evt_valid;
  logic [7:0]                    evt_code;
  logic                          evt_release;
  logic                          evt_extended;
  logic                          evt_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic [7:0]                    err_count;
  logic                          clr_status;

  modport slave (
    input  rx_data, rx_valid, rx_error, evt_ready, clr_status,
    output ps2_clk_inhibit, evt_valid, evt_code, evt_release, evt_extended,
           fifo_count, overflow, err_count
  );

  modport master (
    output rx_data, rx_valid, rx_error, evt_ready, clr_status,
    input  ps2_clk_inhibit, evt_valid, evt_code, evt_release, evt_extended,
           fifo_count, overflow, err_count
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: turns the raw PS/2 Set-2 byte stream into key events.
// Strips E0 (extended) / F0 (break) prefixes, queues events in a FWFT FIFO,
// counts protocol/receive errors (saturating), and inhibits the PS/2 clock
// with hysteresis when the FIFO is nearly full.
// Ports:
//   clk_core   : core clock
//   rst_core_n : asynchronous active-low reset
//   bus        : ps2_kbd_ctrl_if.slave (receiver in, event/status out)
module ps2_kbd_ctrl #(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic           clk_core,
  input  logic           rst_core_n,
  ps2_kbd_ctrl_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } evt_t;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t        state_q, state_d;
  logic [15:0]   timer_q;
  logic          timeout;
  logic          push_req;
  evt_t          push_evt;
  logic          err_inc;

  evt_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          full, do_push, do_pop, drop;
  logic          overflow_q, inhibit_q;
  logic [7:0]    err_q;
  evt_t          head;

  // ---------------- prefix FSM ----------------
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) state_q <= S_IDLE;
    else             state_q <= state_d;

  // A byte arriving on the timeout cycle wins over the timeout.
  assign timeout = (state_q != S_IDLE) && (timer_q >= PREFIX_TIMEOUT);

  always_comb begin
    state_d       = state_q;
    push_req      = 1'b0;
    err_inc       = 1'b0;
    push_evt.code = bus.rx_data;
    push_evt.rel  = 1'b0;
    push_evt.ext  = 1'b0;
    if (bus.rx_error) begin
      state_d = S_IDLE;
      err_inc = 1'b1;
    end else if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == 8'hE0)      state_d = S_EXT;
          else if (bus.rx_data == 8'hF0) state_d = S_BRK;
          else if (bus.rx_data == 8'h00 || bus.rx_data == 8'hFF) err_inc = 1'b1;
          else push_req = 1'b1;
        end
        S_EXT: begin
          if (bus.rx_data == 8'hF0) state_d = S_EXT_BRK;
          else if (bus.rx_data != 8'hE0) begin
            push_req     = 1'b1;
            push_evt.ext = 1'b1;
            state_d      = S_IDLE;
          end
        end
        S_BRK: begin
          if (bus.rx_data == 8'hE0) begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end else if (bus.rx_data != 8'hF0) begin
            push_req     = 1'b1;
            push_evt.rel = 1'b1;
            state_d      = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (bus.rx_data == 8'hE0 || bus.rx_data == 8'hF0) err_inc = 1'b1;
          else begin
            push_req     = 1'b1;
            push_evt.rel = 1'b1;
            push_evt.ext = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
      err_inc = 1'b1;
    end
  end

  // Held at 0 in S_IDLE so every new prefix starts a fresh window.
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n)                                         timer_q <= '0;
    else if (bus.rx_valid || bus.rx_error || state_q == S_IDLE) timer_q <= '0;
    else if (timer_q != 16'hFFFF)                            timer_q <= timer_q + 16'd1;

  // ---------------- error counter ----------------
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n)                      err_q <= '0;
    else if (bus.clr_status)              err_q <= err_inc ? 8'd1 : 8'd0;
    else if (err_inc && err_q != 8'hFF)   err_q <= err_q + 8'd1;

  // ---------------- event FIFO ----------------
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = (count_q != '0) && bus.evt_ready;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  always_ff @(posedge clk_core)
    if (do_push) mem[wr_ptr] <= push_evt;

  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end

  // A drop coincident with clr_status must survive the clear.
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) overflow_q <= 1'b0;
    else             overflow_q <= drop | (overflow_q & ~bus.clr_status);

  // Hysteresis between FIFO_DEPTH-1 and FIFO_DEPTH/2 avoids toggling the
  // PS/2 clock line on every single push/pop near the threshold.
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n)                               inhibit_q <= 1'b0;
    else if (count_q >= CW'(FIFO_DEPTH - 1))       inhibit_q <= 1'b1;
    else if (count_q <= CW'(FIFO_DEPTH / 2))       inhibit_q <= 1'b0;

  // ---------------- outputs ----------------
  // Head is gated so stale (or never-written) storage never leaks out.
  assign head             = mem[rd_ptr];
  assign bus.evt_valid    = (count_q != '0);
  assign bus.evt_code     = bus.evt_valid ? head.code : 8'h00;
  assign bus.evt_release  = bus.evt_valid & head.rel;
  assign bus.evt_extended = bus.evt_valid & head.ext;
  assign bus.fifo_count   = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.err_count    = err_q;
  assign bus.ps2_clk_inhibit = inhibit_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: scoreboard bench for ps2_kbd_ctrl. Expected events are
// queued as bytes are driven and compared when popped from the DUT FIFO.
module tb_ps2_kbd_ctrl;
  localparam int          D  = 8;
  localparam logic [15:0] PT = 16'd40;

  logic clk_core   = 1'b0;
  logic rst_core_n = 1'b0;
  always #5 clk_core = ~clk_core;

  ps2_kbd_ctrl_if #(.FIFO_DEPTH(D)) bus();

  ps2_kbd_ctrl #(.FIFO_DEPTH(D), .PREFIX_TIMEOUT(PT)) dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .bus        (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_evt(input logic [7:0] code, input logic rel, input logic ext);
    exp_q.push_back({code, rel, ext});
  endtask

  // All drive tasks start and end on a negedge.
  task automatic send(input logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    @(negedge clk_core);
    bus.rx_valid = 1'b0;
  endtask

  task automatic rx_err();
    bus.rx_error = 1'b1;
    @(negedge clk_core);
    bus.rx_error = 1'b0;
  endtask

  task automatic clr();
    bus.clr_status = 1'b1;
    @(negedge clk_core);
    bus.clr_status = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  task automatic pop_chk(input string tag);
    logic [9:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
    chk({tag, "_valid"}, bus.evt_valid, 1);
    chk(tag, {bus.evt_code, bus.evt_release, bus.evt_extended}, e);
    bus.evt_ready = 1'b1;
    @(negedge clk_core);
    bus.evt_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) pop_chk(tag);
    chk({tag, "_empty"}, bus.evt_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data = '0; bus.rx_valid = 0; bus.rx_error = 0;
    bus.evt_ready = 0; bus.clr_status = 0;
    idle(3);
    chk("rst_valid", bus.evt_valid, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_err",   bus.err_count, 0);
    chk("rst_ovf",   bus.overflow, 0);
    chk("rst_inh",   bus.ps2_clk_inhibit, 0);
    chk("rst_code",  bus.evt_code, 0);
    rst_core_n = 1'b1;
    idle(1);

    // make and break
    send(8'h1C); exp_evt(8'h1C, 0, 0);
    chk("push_latency", bus.evt_valid, 1);
    send(8'hF0); send(8'h1C); exp_evt(8'h1C, 1, 0);
    chk("mb_count", bus.fifo_count, 2);
    chk("mb_err",   bus.err_count, 0);
    drain("mb");

    // extended make and break
    send(8'hE0); send(8'h74); exp_evt(8'h74, 0, 1);
    send(8'hE0); send(8'hF0); send(8'h74); exp_evt(8'h74, 1, 1);
    drain("ext");

    // rx_error discards a pending prefix
    send(8'hE0); rx_err(); send(8'h1C); exp_evt(8'h1C, 0, 0);
    chk("rxerr_err",   bus.err_count, 1);
    chk("rxerr_count", bus.fifo_count, 1);
    drain("rxerr");

    // prefix timeout turns the next byte into a make
    send(8'hF0); idle(PT + 10); send(8'h1C); exp_evt(8'h1C, 0, 0);
    chk("tmo_err", bus.err_count, 2);
    drain("tmo");

    // short gap stays inside the window: still a break
    send(8'hF0); idle(PT - 10); send(8'h1C); exp_evt(8'h1C, 1, 0);
    chk("notmo_err", bus.err_count, 2);
    drain("notmo");

    clr();
    chk("clr_err", bus.err_count, 0);

    // overrun codes, protocol errors, E1 passthrough, repeated prefixes
    send(8'h00); send(8'hFF);
    send(8'hF0); send(8'hE0);
    send(8'hE0); send(8'hF0); send(8'hE0);
    send(8'hE1); exp_evt(8'hE1, 0, 0);
    send(8'hE0); send(8'hE0); send(8'h11); exp_evt(8'h11, 0, 1);
    send(8'hF0); send(8'hF0); send(8'h12); exp_evt(8'h12, 1, 0);
    chk("proto_err", bus.err_count, 4);
    drain("proto");

    // fill past full with no consumer
    for (int k = 1; k <= 9; k++) begin
      send(8'(k));
      if (k <= D) exp_evt(8'(k), 0, 0);
      if (k == 6) chk("inh_at6", bus.ps2_clk_inhibit, 0);
      if (k == 7) chk("inh_lag7", bus.ps2_clk_inhibit, 0);
      if (k == 8) chk("inh_set", bus.ps2_clk_inhibit, 1);
    end
    chk("full_count", bus.fifo_count, D);
    chk("full_ovf",   bus.overflow, 1);
    chk("full_head",  bus.evt_code, 8'h01);

    // simultaneous push and pop at full
    begin
      logic [9:0] e;
      e = exp_q.pop_front();
      chk("pp_head", {bus.evt_code, bus.evt_release, bus.evt_extended}, e);
      bus.rx_data = 8'h0A; bus.rx_valid = 1'b1; bus.evt_ready = 1'b1;
      exp_evt(8'h0A, 0, 0);
      @(negedge clk_core);
      bus.rx_valid = 1'b0; bus.evt_ready = 1'b0;
    end
    chk("pp_count", bus.fifo_count, D);
    chk("pp_ovf",   bus.overflow, 1);

    for (int i = 0; i < 4; i++) pop_chk("pop4");
    chk("pop4_count", bus.fifo_count, 4);
    chk("inh_hyst",   bus.ps2_clk_inhibit, 1);
    idle(1);
    chk("inh_clr",    bus.ps2_clk_inhibit, 0);
    drain("rest");
    chk("rest_count", bus.fifo_count, 0);
    clr();
    chk("ovf_clr", bus.overflow, 0);

    // saturation
    for (int i = 0; i < 300; i++) rx_err();
    chk("sat_err", bus.err_count, 255);
    bus.clr_status = 1'b1; bus.rx_error = 1'b1;
    @(negedge clk_core);
    bus.clr_status = 1'b0; bus.rx_error = 1'b0;
    chk("clr_inc_err", bus.err_count, 1);

    // asynchronous reset mid-sequence
    send(8'h22); send(8'h33); send(8'hE0);
    rst_core_n = 1'b0;
    #1;
    chk("mrst_valid", bus.evt_valid, 0);
    chk("mrst_count", bus.fifo_count, 0);
    chk("mrst_err",   bus.err_count, 0);
    chk("mrst_code",  bus.evt_code, 0);
    exp_q.delete();
    @(negedge clk_core);
    rst_core_n = 1'b1;
    idle(1);
    send(8'h44); exp_evt(8'h44, 0, 0);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
